pc_branch_unit: RTL and testbench
=================================

Name: pc_branch_unit

Overview:
Owns the fetch PC register and resolves control flow from the ALU's outputs: the ALU compare flag EQ and ALUout, which carries the JALR target. It decides taken or not-taken for BEQ, BNE, JAL and JALR, redirects the PC, and issues a multi-cycle flush to squash the wrong-path instructions. It sits between the execute stage (ALU) and instruction fetch.

Parameters:
DATA_WIDTH, 32, width of PC, immediate and ALU result
RESET_PC, 32'h0000_0000, PC value loaded on reset
FLUSH_CYCLES, 2, cycles flush stays high after a taken redirect; must be >= 1 (elaboration-time check)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
stall  input  1  hold PC this cycle (fetch back-pressure)
ex_valid  input  1  execute stage presents an instruction to resolve
ex_ready  output  1  unit accepts resolution this cycle
ex_btype  input  3  branch type, btype_t
ex_pc  input  DATA_WIDTH  PC of the resolving instruction
ex_imm  input  DATA_WIDTH  sign-extended branch/jump offset
ALUout  input  DATA_WIDTH  ALU result (rs1+imm for JALR)
EQ  input  1  ALU equality flag (1 when operands are equal)
pc  output  DATA_WIDTH  current fetch PC
flush  output  1  squash younger in-flight instructions

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, flush=0, ex_ready=1, state=RUN, flush counter=0.
  - Reset mid-flush aborts the flush and forces RUN.
- States:
  - RUN: ex_ready=1, flush=0.
  - FLUSH: ex_ready=0, flush=1.
- Resolution fires when ex_valid && ex_ready.
- Taken decision:
  - BT_BEQ: taken = EQ.
  - BT_BNE: taken = !EQ.
  - BT_JAL, BT_JALR: taken = 1.
  - BT_NONE: taken = 0.
  - Codes 5-7 are treated as BT_NONE.
- Target:
  - BEQ/BNE/JAL: ex_pc + ex_imm.
  - JALR: ALUout & ~1.
  - Bit 0 of every target is cleared. No misalignment trap.
- Next-PC priority, registered, one cycle latency:
  1. Taken resolution: pc <= target. This wins over stall.
  2. stall: pc holds.
  3. Otherwise: pc <= pc + 4, wrapping modulo 2^DATA_WIDTH.
- Taken resolution in RUN:
  - Next cycle: state=FLUSH, flush=1, counter=FLUSH_CYCLES-1.
  - Not-taken and BT_NONE never leave RUN.
- In FLUSH:
  - Counter decrements every cycle, independent of stall.
  - When counter==0, the next cycle returns to RUN.
  - flush is high for exactly FLUSH_CYCLES cycles.
  - pc keeps advancing by +4 from the target, subject to stall.
- ex_valid while ex_ready=0: ignored. The instruction is squashed and no state changes.
- Back-to-back taken branches can only occur after FLUSH ends. The first one accepted in RUN wins.
- flush and ex_ready are registered-state decodes only; there is no combinational path from inputs.

Optional Feature:
BRANCH_STATS_EN
- Defined:
  - Adds outputs resolved_cnt[31:0] (increments on every resolution of a BEQ/BNE/JAL/JALR) and taken_cnt[31:0] (increments on every taken resolution).
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package branch_pkg:
  - typedef enum logic[2:0] btype_t {BT_NONE=0, BT_BEQ=1, BT_BNE=2, BT_JAL=3, BT_JALR=4}.
  - typedef enum logic state_t {RUN, FLUSH}.
  - constant PC_STEP=4.
- Sub-module branch_decide (combinational): inputs btype, EQ, ex_pc, ex_imm, ALUout; outputs taken, target.
- pc_branch_unit holds the PC register, FSM and flush counter.

Test Plan:
- Reset release with RESET_PC=0 and no stall -> pc = 0, 4, 8, 12 on successive cycles; flush=0; ex_ready=1.
- BEQ at ex_pc=0x40, ex_imm=0x20, EQ=1 -> next cycle pc=0x60, flush=1 for 2 cycles, ex_ready=0 during them, then pc=0x68 and RUN. Same stimulus with EQ=0 -> pc continues +4, flush stays 0.
- BNE with EQ=0, JAL with ex_imm=-8 (0xFFFF_FFF8) at ex_pc=0x100 -> BNE taken; JAL gives pc=0xF8. Negative offset sign-wraps correctly.
- JALR with ALUout=0x0000_1235 while stall=1 -> pc=0x1234 (bit 0 cleared, redirect wins over stall); next cycle with stall=1 -> pc holds 0x1234.
- ex_valid with a taken BEQ asserted during FLUSH -> ignored: pc unaffected, flush length unchanged. rst_n pulsed low mid-FLUSH -> pc=RESET_PC, flush=0, ex_ready=1 immediately.
- pc=0xFFFF_FFFC with no branch -> pc wraps to 0. With BRANCH_STATS_EN, 3 branches of which 2 are taken -> resolved_cnt=3, taken_cnt=2.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared definitions for the PC / branch resolution unit.
//   btype_t : branch type encoding carried on ex_btype
//   state_t : control FSM states (RUN accepts resolutions, FLUSH squashes)
//   PC_STEP : sequential fetch increment in bytes
package branch_pkg;

  typedef enum logic [2:0] {
    BT_NONE = 3'd0,
    BT_BEQ  = 3'd1,
    BT_BNE  = 3'd2,
    BT_JAL  = 3'd3,
    BT_JALR = 3'd4
  } btype_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam int PC_STEP = 4;

endpackage

// File: rtl/branch_decide.sv
// Combinational taken/target decision for one resolving instruction.
// Ports:
//   btype  in  3   branch type (btype_t encoding, 5-7 behave as BT_NONE)
//   EQ     in  1   ALU equality flag
//   ex_pc  in  DW  PC of the resolving instruction
//   ex_imm in  DW  sign-extended offset
//   ALUout in  DW  ALU result, JALR target before alignment
//   taken  out 1   redirect required
//   target out DW  redirect address, bit 0 always cleared
module branch_decide
  import branch_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            btype,
  input  logic                  EQ,
  input  logic [DATA_WIDTH-1:0] ex_pc,
  input  logic [DATA_WIDTH-1:0] ex_imm,
  input  logic [DATA_WIDTH-1:0] ALUout,
  output logic                  taken,
  output logic [DATA_WIDTH-1:0] target
);

  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~{{(DATA_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] target_raw;

  always_comb begin
    taken = 1'b0;
    case (btype)
      BT_BEQ:          taken = EQ;
      BT_BNE:          taken = !EQ;
      BT_JAL, BT_JALR: taken = 1'b1;
      default:         taken = 1'b0;
    endcase
  end

  // The add wraps modulo 2^DATA_WIDTH, so negative offsets come out right.
  assign target_raw = (btype == BT_JALR) ? ALUout : (ex_pc + ex_imm);
  assign target     = target_raw & ALIGN_MASK;

endmodule

// File: rtl/pc_branch_unit.sv
// Fetch PC register plus branch resolution and wrong-path flush control.
// After a taken resolution the PC is redirected and flush is held for
// FLUSH_CYCLES cycles, during which new resolutions are refused.
// Optional feature macro: BRANCH_STATS_EN adds resolved_cnt / taken_cnt.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   stall             hold PC this cycle (a taken redirect still wins)
//   ex_valid/ex_ready resolution handshake; ex_ready=1 only in RUN
//   ex_btype          branch type (btype_t)
//   ex_pc, ex_imm     PC and offset of the resolving instruction
//   ALUout, EQ        ALU result (JALR target) and equality flag
//   pc                current fetch PC
//   flush             squash younger in-flight instructions
//   resolved_cnt      (BRANCH_STATS_EN) saturating count of real branch resolutions
//   taken_cnt         (BRANCH_STATS_EN) saturating count of taken resolutions
module pc_branch_unit
  import branch_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = '0,
  parameter int                    FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [2:0]            ex_btype,
  input  logic [DATA_WIDTH-1:0] ex_pc,
  input  logic [DATA_WIDTH-1:0] ex_imm,
  input  logic [DATA_WIDTH-1:0] ALUout,
  input  logic                  EQ,
`ifdef BRANCH_STATS_EN
  output logic [31:0]           resolved_cnt,
  output logic [31:0]           taken_cnt,
`endif
  output logic [DATA_WIDTH-1:0] pc,
  output logic                  flush
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  generate
    if (FLUSH_CYCLES < 1) begin : g_bad_flush_cycles
      $error("pc_branch_unit: FLUSH_CYCLES must be >= 1");
    end
  endgenerate

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0] pc_reg, pc_next;

  logic                  taken;
  logic [DATA_WIDTH-1:0] target;
  logic                  fire;
  logic                  redirect;

  branch_decide #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_decide (
    .btype (ex_btype),
    .EQ    (EQ),
    .ex_pc (ex_pc),
    .ex_imm(ex_imm),
    .ALUout(ALUout),
    .taken (taken),
    .target(target)
  );

  // Handshake outputs decode registered state only.
  assign ex_ready = (state_reg == RUN);
  assign flush    = (state_reg == FLUSH);
  assign pc       = pc_reg;

  assign fire     = ex_valid && ex_ready;
  assign redirect = fire && taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
      pc_reg    <= RESET_PC;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pc_reg    <= pc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;

    // Redirect beats stall; otherwise sequential fetch.
    if (redirect)
      pc_next = target;
    else if (stall)
      pc_next = pc_reg;
    else
      pc_next = pc_reg + DATA_WIDTH'(PC_STEP);

    case (state_reg)
      RUN: begin
        if (redirect) begin
          state_next = FLUSH;
          cnt_next   = CNT_LOAD;
        end
      end
      FLUSH: begin
        // The counter runs regardless of stall so flush length is fixed.
        if (cnt_reg == '0)
          state_next = RUN;
        else
          cnt_next = cnt_reg - 1'b1;
      end
      default: begin
        state_next = RUN;
        cnt_next   = '0;
      end
    endcase
  end

`ifdef BRANCH_STATS_EN
  logic real_branch;

  // Codes 5-7 are not branches and are not counted.
  assign real_branch = (ex_btype == BT_BEQ) || (ex_btype == BT_BNE) ||
                       (ex_btype == BT_JAL) || (ex_btype == BT_JALR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resolved_cnt <= '0;
      taken_cnt    <= '0;
    end else begin
      if (fire && real_branch && (resolved_cnt != 32'hFFFF_FFFF))
        resolved_cnt <= resolved_cnt + 32'd1;
      if (redirect && (taken_cnt != 32'hFFFF_FFFF))
        taken_cnt <= taken_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
module tb_pc_branch_unit;
  import branch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        ex_valid;
  logic        ex_ready;
  logic [2:0]  ex_btype;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ALUout;
  logic        EQ;
  logic [31:0] pc;
  logic        flush;
`ifdef BRANCH_STATS_EN
  logic [31:0] resolved_cnt;
  logic [31:0] taken_cnt;
`endif

  pc_branch_unit #(
    .DATA_WIDTH  (32),
    .RESET_PC    (32'h0000_0000),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .stall   (stall),
    .ex_valid(ex_valid),
    .ex_ready(ex_ready),
    .ex_btype(ex_btype),
    .ex_pc   (ex_pc),
    .ex_imm  (ex_imm),
    .ALUout  (ALUout),
    .EQ      (EQ),
`ifdef BRANCH_STATS_EN
    .resolved_cnt(resolved_cnt),
    .taken_cnt   (taken_cnt),
`endif
    .pc      (pc),
    .flush   (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        valid;
    logic [2:0]  btype;
    logic [31:0] ex_pc;
    logic [31:0] imm;
    logic [31:0] alu;
    logic        eq;
    logic [31:0] exp_pc;
    logic        exp_flush;
    logic        exp_ready;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] pc;
    logic        flush;
    logic        ready;
  } exp_t;

  localparam int NV = 22;
  vec_t vecs[NV];
  exp_t sb[$];
  exp_t e;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic v, input logic [2:0] bt,
                              input logic [31:0] p, input logic [31:0] im,
                              input logic [31:0] a, input logic q,
                              input logic [31:0] xp, input logic xf, input logic xr);
    vec_t r;
    r.stall = st; r.valid = v; r.btype = bt; r.ex_pc = p; r.imm = im; r.alu = a;
    r.eq = q; r.exp_pc = xp; r.exp_flush = xf; r.exp_ready = xr;
    return r;
  endfunction

  initial begin
    //            stall valid btype    ex_pc         imm           ALUout        EQ   pc            flush ready
    vecs[0]  = mk(1'b0, 1'b0, BT_NONE, 32'h0,        32'h0,        32'h0,        1'b0, 32'h0000_0004, 1'b0, 1'b1);
    vecs[1]  = mk(1'b0, 1'b0, BT_NONE, 32'h0,        32'h0,        32'h0,        1'b0, 32'h0000_0008, 1'b0, 1'b1);
    vecs[2]  = mk(1'b0, 1'b0, BT_NONE, 32'h0,        32'h0,        32'h0,        1'b0, 32'h0000_000C, 1'b0, 1'b1);
    // BEQ taken: redirect to 0x60, two flush cycles, then RUN at 0x68
    vecs[3]  = mk(1'b0, 1'b1, BT_BEQ,  32'h40,       32'h20,       32'h0,        1'b1, 32'h0000_0060, 1'b1, 1'b0);
    vecs[4]  = mk(1'b0, 1'b0, BT_NONE, 32'h0,        32'h0,        32'h0,        1'b0, 32'h0000_0064, 1'b1, 1'b0);
    vecs[5]  = mk(1'b0, 1'b0, BT_NONE, 32'h0,        32'h0,        32'h0,        1'b0, 32'h0000_0068, 1'b0, 1'b1);
    // BEQ not taken
    vecs[6]  = mk(1'b0, 1'b1, BT_BEQ,  32'h40,       32'h20,       32'h0,        1'b0, 32'h0000_006C, 1'b0, 1'b1);
    // BNE taken
    vecs[7]  = mk(1'b0, 1'b1, BT_BNE,  32'h100,      32'h10,       32'h0,        1'b0, 32'h0000_0110, 1'b1, 1'b0);
    vecs[8]  = mk(1'b0, 1'b0, BT_NONE, 32'h0,        32'h0,        32'h0,        1'b0, 32'h0000_0114, 1'b1, 1'b0);
    vecs[9]  = mk(1'b0, 1'b0, BT_NONE, 32'h0,        32'h0,        32'h0,        1'b0, 32'h0000_0118, 1'b0, 1'b1);
    // JAL with negative offset
    vecs[10] = mk(1'b0, 1'b1, BT_JAL,  32'h100,      32'hFFFF_FFF8, 32'h0,       1'b0, 32'h0000_00F8, 1'b1, 1'b0);
    vecs[11] = mk(1'b0, 1'b0, BT_NONE, 32'h0,        32'h0,        32'h0,        1'b0, 32'h0000_00FC, 1'b1, 1'b0);
    vecs[12] = mk(1'b0, 1'b0, BT_NONE, 32'h0,        32'h0,        32'h0,        1'b0, 32'h0000_0100, 1'b0, 1'b1);
    // JALR under stall: redirect wins, bit 0 cleared
    vecs[13] = mk(1'b1, 1'b1, BT_JALR, 32'h0,        32'h0,        32'h0000_1235, 1'b0, 32'h0000_1234, 1'b1, 1'b0);
    // stall holds; taken BEQ during FLUSH is ignored
    vecs[14] = mk(1'b1, 1'b1, BT_BEQ,  32'h40,       32'h20,       32'h0,        1'b1, 32'h0000_1234, 1'b1, 1'b0);
    vecs[15] = mk(1'b0, 1'b1, BT_BEQ,  32'h40,       32'h20,       32'h0,        1'b1, 32'h0000_1238, 1'b0, 1'b1);
    // BNE not taken, reserved code 5 acts as no branch, plain stall
    vecs[16] = mk(1'b0, 1'b1, BT_BNE,  32'h40,       32'h20,       32'h0,        1'b1, 32'h0000_123C, 1'b0, 1'b1);
    vecs[17] = mk(1'b0, 1'b1, 3'd5,    32'h40,       32'h20,       32'h0,        1'b1, 32'h0000_1240, 1'b0, 1'b1);
    vecs[18] = mk(1'b1, 1'b0, BT_NONE, 32'h0,        32'h0,        32'h0,        1'b0, 32'h0000_1240, 1'b0, 1'b1);
    // JALR to top of address space, then wrap to 0
    vecs[19] = mk(1'b0, 1'b1, BT_JALR, 32'h0,        32'h0,        32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFC, 1'b1, 1'b0);
    vecs[20] = mk(1'b0, 1'b0, BT_NONE, 32'h0,        32'h0,        32'h0,        1'b0, 32'h0000_0000, 1'b1, 1'b0);
    vecs[21] = mk(1'b0, 1'b0, BT_NONE, 32'h0,        32'h0,        32'h0,        1'b0, 32'h0000_0004, 1'b0, 1'b1);

    rst_n = 1'b0; stall = 1'b0; ex_valid = 1'b0; ex_btype = 3'd0;
    ex_pc = '0; ex_imm = '0; ALUout = '0; EQ = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_pc", pc, 32'h0);
    check("reset_flush", {31'b0, flush}, 32'd0);
    check("reset_ready", {31'b0, ex_ready}, 32'd1);
`ifdef BRANCH_STATS_EN
    check("reset_resolved_cnt", resolved_cnt, 32'd0);
    check("reset_taken_cnt", taken_cnt, 32'd0);
`endif

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      stall    = vecs[i].stall;
      ex_valid = vecs[i].valid;
      ex_btype = vecs[i].btype;
      ex_pc    = vecs[i].ex_pc;
      ex_imm   = vecs[i].imm;
      ALUout   = vecs[i].alu;
      EQ       = vecs[i].eq;
      sb.push_back('{idx: i, pc: vecs[i].exp_pc, flush: vecs[i].exp_flush, ready: vecs[i].exp_ready});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check($sformatf("v%0d_pc", e.idx), pc, e.pc);
      check($sformatf("v%0d_flush", e.idx), {31'b0, flush}, {31'b0, e.flush});
      check($sformatf("v%0d_ready", e.idx), {31'b0, ex_ready}, {31'b0, e.ready});
      $display("vec %0d: pc=0x%08h flush=%0b ex_ready=%0b", e.idx, pc, flush, ex_ready);
      @(negedge clk);
    end
    ex_valid = 1'b0; stall = 1'b0;

`ifdef BRANCH_STATS_EN
    // Resolutions: BEQ,BEQ,BNE,JAL,JALR,BNE,JALR = 7; taken: 5.
    check("resolved_cnt", resolved_cnt, 32'd7);
    check("taken_cnt", taken_cnt, 32'd5);
`endif

    // Reset asserted in the middle of a flush takes effect immediately.
    ex_valid = 1'b1; ex_btype = BT_JAL; ex_pc = 32'h0; ex_imm = 32'h80;
    @(posedge clk);
    #1;
    check("midflush_pre_pc", pc, 32'h80);
    check("midflush_pre_flush", {31'b0, flush}, 32'd1);
    ex_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midflush_rst_pc", pc, 32'h0);
    check("midflush_rst_flush", {31'b0, flush}, 32'd0);
    check("midflush_rst_ready", {31'b0, ex_ready}, 32'd1);
    $display("async reset mid-flush: pc=0x%08h flush=%0b ex_ready=%0b", pc, flush, ex_ready);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_pc", pc, 32'h4);
    check("post_rst_flush", {31'b0, flush}, 32'd0);
`ifdef BRANCH_STATS_EN
    check("post_rst_resolved_cnt", resolved_cnt, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
